// File: rtl/latch_bank_pkg.sv
// latch_pkg: shared mode constants and channel slicing helper for latch_bank.
package latch_pkg;
  localparam int MODE_REG = 0;
  localparam int MODE_TRANSP = 1;
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/latch_bank_if.sv
// latch_bank_if: data/control bundle for latch_bank; q_par exists only with LATCH_BANK_PARITY_EN.
interface latch_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int CNT_W = 8
);
  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0] enable;
  logic freeze;
  logic clr_chg;
  logic cnt_clr;
  logic [NCH*WIDTH-1:0] q;
  logic [NCH-1:0] chg;
  logic any_chg;
  logic [CNT_W-1:0] load_cnt;
`ifdef LATCH_BANK_PARITY_EN
  logic [NCH-1:0] q_par;
  modport master (output din, enable, freeze, clr_chg, cnt_clr, input q, chg, any_chg, load_cnt, q_par);
  modport slave (input din, enable, freeze, clr_chg, cnt_clr, output q, chg, any_chg, load_cnt, q_par);
`else
  modport master (output din, enable, freeze, clr_chg, cnt_clr, input q, chg, any_chg, load_cnt);
  modport slave (input din, enable, freeze, clr_chg, cnt_clr, output q, chg, any_chg, load_cnt);
`endif
endinterface

// File: rtl/latch_bank_cell.sv
// latch_cell: one enable-gated hold channel with change flag; parity under LATCH_BANK_PARITY_EN.
module latch_cell import latch_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MODE = MODE_REG,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic ld,
  input  logic clr,
  output logic [WIDTH-1:0] q,
  output logic chg
`ifdef LATCH_BANK_PARITY_EN
  ,
  output logic q_par
`endif
);
  logic [WIDTH-1:0] stored;
  logic bypass;
  // Gating with rst_n keeps the transparent path showing RST_VAL while in reset.
  assign bypass = (MODE == MODE_TRANSP) && ld && rst_n;
  assign q = bypass ? d : stored;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored <= RST_VAL;
      chg <= 1'b0;
    end else begin
      stored <= ld ? d : stored;
      chg <= (ld && (d != stored)) || (chg && !clr);
    end
  end
`ifdef LATCH_BANK_PARITY_EN
  logic par_r;
  assign q_par = bypass ? ^d : par_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_r <= ^RST_VAL;
    else par_r <= ld ? ^d : par_r;
  end
`endif
endmodule

// File: rtl/latch_bank.sv
// latch_bank: NCH-channel capture bank with freeze, change flags and saturating load counter.
// Optional q_par output enabled by LATCH_BANK_PARITY_EN.
module latch_bank import latch_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int MODE = MODE_REG,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  latch_bank_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [NCH-1:0] ld;
  logic [NCH-1:0] chg;
  logic [NCH*WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  assign ld = bus.enable & {NCH{~bus.freeze}};
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    latch_cell #(.WIDTH(WIDTH), .MODE(MODE), .RST_VAL(RST_VAL)) u_cell (
      .clk(clk),
      .rst_n(rst_n),
      .d(bus.din[ch_lsb(i, WIDTH) +: WIDTH]),
      .ld(ld[i]),
      .clr(bus.clr_chg),
      .q(q[ch_lsb(i, WIDTH) +: WIDTH]),
      .chg(chg[i])
`ifdef LATCH_BANK_PARITY_EN
      ,
      .q_par(bus.q_par[i])
`endif
    );
  end
  // Counts cycles with any load, not channels loaded; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= bus.cnt_clr ? '0 : ((|ld && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt);
  end
  assign bus.q = q;
  assign bus.chg = chg;
  assign bus.any_chg = |chg;
  assign bus.load_cnt = cnt;
endmodule
